// File: rtl/control_unit.sv
// ID-stage decode/control for the 5-stage RV32I pipeline: maps the decoded opcode to the
// datapath control bundle, with a sticky illegal-opcode flag and an optional output register.

package opcodes_pkg;
    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
        OP_FENCE, OP_ECALL, OP_EBREAK
    } opcode_out_t;
endpackage

package control_types_pkg;
    typedef enum logic [2:0] {
        BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } comp_op_t;

    typedef enum logic [1:0] {
        WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PC4
    } reg_wr_src_t;

    typedef enum logic {SRC1_REG1, SRC1_PC} alu_src1_t;
    typedef enum logic {SRC2_REG2, SRC2_IMM} alu_src2_t;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_t;

    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    typedef struct packed {
        logic        reg_wr;
        logic        mem_wr;
        logic        mem_rd;
        logic        branch;
        logic        jump;
        comp_op_t    comp;
        reg_wr_src_t wr_src;
        alu_src1_t   src1;
        alu_src2_t   src2;
        alu_op_t     alu;
        mem_op_t     mem;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_DEFAULT = '{
        reg_wr: 1'b0, mem_wr: 1'b0, mem_rd: 1'b0, branch: 1'b0, jump: 1'b0,
        comp: BR_NOP, wr_src: WRSRC_ALURES, src1: SRC1_REG1, src2: SRC2_REG2,
        alu: ALU_NOP, mem: MEM_NOP
    };
endpackage

module control_unit
    import opcodes_pkg::*;
    import control_types_pkg::*;
#(
    parameter bit REGISTERED_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  opcode_out_t opcode_in,
    output logic        reg_do_write_ctrl,
    output logic        mem_do_write_ctrl,
    output logic        mem_do_read_ctrl,
    output logic        do_branch,
    output logic        do_jump,
    output comp_op_t    comp_ctrl,
    output reg_wr_src_t reg_wr_src_ctrl,
    output alu_src1_t   alu_src1_ctrl,
    output alu_src2_t   alu_src2_ctrl,
    output alu_op_t     alu_ctrl,
    output mem_op_t     mem_ctrl,
    output logic        illegal_op
);

    ctrl_bundle_t w_ctrl;
    ctrl_bundle_t w_out;
    logic         w_illegal;
    logic         r_illegal;

    function automatic ctrl_bundle_t f_alu(input alu_op_t op, input alu_src2_t src2);
        ctrl_bundle_t b;
        b        = CTRL_DEFAULT;
        b.reg_wr = 1'b1;
        b.src2   = src2;
        b.alu    = op;
        return b;
    endfunction

    function automatic ctrl_bundle_t f_load(input mem_op_t op);
        ctrl_bundle_t b;
        b        = f_alu(ALU_ADD, SRC2_IMM);
        b.mem_rd = 1'b1;
        b.wr_src = WRSRC_MEMREAD;
        b.mem    = op;
        return b;
    endfunction

    function automatic ctrl_bundle_t f_store(input mem_op_t op);
        ctrl_bundle_t b;
        b        = f_alu(ALU_ADD, SRC2_IMM);
        b.reg_wr = 1'b0;
        b.mem_wr = 1'b1;
        b.mem    = op;
        return b;
    endfunction

    // Branch target is computed in the ALU as PC + imm; the compare happens in EX.
    function automatic ctrl_bundle_t f_branch(input comp_op_t op);
        ctrl_bundle_t b;
        b        = CTRL_DEFAULT;
        b.branch = 1'b1;
        b.comp   = op;
        b.src1   = SRC1_PC;
        b.src2   = SRC2_IMM;
        b.alu    = ALU_ADD;
        return b;
    endfunction

    function automatic ctrl_bundle_t f_jump(input alu_src1_t src1);
        ctrl_bundle_t b;
        b        = f_alu(ALU_ADD, SRC2_IMM);
        b.jump   = 1'b1;
        b.wr_src = WRSRC_PC4;
        b.src1   = src1;
        return b;
    endfunction

    always_comb begin
        w_ctrl    = CTRL_DEFAULT;
        w_illegal = 1'b0;
        case (opcode_in)
            OP_NOP:   w_ctrl = CTRL_DEFAULT;
            OP_ADD:   w_ctrl = f_alu(ALU_ADD,  SRC2_REG2);
            OP_SUB:   w_ctrl = f_alu(ALU_SUB,  SRC2_REG2);
            OP_AND:   w_ctrl = f_alu(ALU_AND,  SRC2_REG2);
            OP_OR:    w_ctrl = f_alu(ALU_OR,   SRC2_REG2);
            OP_XOR:   w_ctrl = f_alu(ALU_XOR,  SRC2_REG2);
            OP_SLL:   w_ctrl = f_alu(ALU_SLL,  SRC2_REG2);
            OP_SRL:   w_ctrl = f_alu(ALU_SRL,  SRC2_REG2);
            OP_SRA:   w_ctrl = f_alu(ALU_SRA,  SRC2_REG2);
            OP_SLT:   w_ctrl = f_alu(ALU_SLT,  SRC2_REG2);
            OP_SLTU:  w_ctrl = f_alu(ALU_SLTU, SRC2_REG2);
            OP_ADDI:  w_ctrl = f_alu(ALU_ADD,  SRC2_IMM);
            OP_ANDI:  w_ctrl = f_alu(ALU_AND,  SRC2_IMM);
            OP_ORI:   w_ctrl = f_alu(ALU_OR,   SRC2_IMM);
            OP_XORI:  w_ctrl = f_alu(ALU_XOR,  SRC2_IMM);
            OP_SLLI:  w_ctrl = f_alu(ALU_SLL,  SRC2_IMM);
            OP_SRLI:  w_ctrl = f_alu(ALU_SRL,  SRC2_IMM);
            OP_SRAI:  w_ctrl = f_alu(ALU_SRA,  SRC2_IMM);
            OP_SLTI:  w_ctrl = f_alu(ALU_SLT,  SRC2_IMM);
            OP_SLTIU: w_ctrl = f_alu(ALU_SLTU, SRC2_IMM);
            OP_LB:    w_ctrl = f_load(MEM_LB);
            OP_LH:    w_ctrl = f_load(MEM_LH);
            OP_LW:    w_ctrl = f_load(MEM_LW);
            OP_LBU:   w_ctrl = f_load(MEM_LBU);
            OP_LHU:   w_ctrl = f_load(MEM_LHU);
            OP_SB:    w_ctrl = f_store(MEM_SB);
            OP_SH:    w_ctrl = f_store(MEM_SH);
            OP_SW:    w_ctrl = f_store(MEM_SW);
            OP_BEQ:   w_ctrl = f_branch(BR_EQ);
            OP_BNE:   w_ctrl = f_branch(BR_NE);
            OP_BLT:   w_ctrl = f_branch(BR_LT);
            OP_BGE:   w_ctrl = f_branch(BR_GE);
            OP_BLTU:  w_ctrl = f_branch(BR_LTU);
            OP_BGEU:  w_ctrl = f_branch(BR_GEU);
            OP_JAL:   w_ctrl = f_jump(SRC1_PC);
            OP_JALR:  w_ctrl = f_jump(SRC1_REG1);
            // src1 is unused by ALU_LUI; REG1 keeps the forwarding mux quiet.
            OP_LUI:   w_ctrl = f_alu(ALU_LUI, SRC2_IMM);
            OP_AUIPC: begin
                w_ctrl      = f_alu(ALU_ADD, SRC2_IMM);
                w_ctrl.src1 = SRC1_PC;
            end
            default:  w_illegal = 1'b1;
        endcase
    end

    generate
        if (REGISTERED_OUT) begin : g_reg
            ctrl_bundle_t r_ctrl;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ctrl <= CTRL_DEFAULT;
                end else begin
                    r_ctrl <= w_ctrl;
                end
            end

            assign w_out = r_ctrl;
        end else begin : g_comb
            assign w_out = w_ctrl;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign reg_do_write_ctrl = w_out.reg_wr;
    assign mem_do_write_ctrl = w_out.mem_wr;
    assign mem_do_read_ctrl  = w_out.mem_rd;
    assign do_branch         = w_out.branch;
    assign do_jump           = w_out.jump;
    assign comp_ctrl         = w_out.comp;
    assign reg_wr_src_ctrl   = w_out.wr_src;
    assign alu_src1_ctrl     = w_out.src1;
    assign alu_src2_ctrl     = w_out.src2;
    assign alu_ctrl          = w_out.alu;
    assign mem_ctrl          = w_out.mem;
    assign illegal_op        = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: combinational and registered instances share stimulus.

module tb_control_unit;
    import opcodes_pkg::*;
    import control_types_pkg::*;

    typedef struct packed {
        logic        wr;
        logic        mwr;
        logic        mrd;
        logic        br;
        logic        jmp;
        comp_op_t    comp;
        reg_wr_src_t src;
        alu_src1_t   s1;
        alu_src2_t   s2;
        alu_op_t     alu;
        mem_op_t     mem;
    } exp_t;

    logic        clk;
    logic        rst_n;
    opcode_out_t opcode;

    logic        c_wr, c_mwr, c_mrd, c_br, c_jmp, c_ill;
    comp_op_t    c_comp;
    reg_wr_src_t c_src;
    alu_src1_t   c_s1;
    alu_src2_t   c_s2;
    alu_op_t     c_alu;
    mem_op_t     c_mem;

    logic        r_wr, r_mwr, r_mrd, r_br, r_jmp, r_ill;
    comp_op_t    r_comp;
    reg_wr_src_t r_src;
    alu_src1_t   r_s1;
    alu_src2_t   r_s2;
    alu_op_t     r_alu;
    mem_op_t     r_mem;

    exp_t got_c;
    exp_t got_r;
    int   checks = 0;
    int   passed = 0;

    assign got_c = {c_wr, c_mwr, c_mrd, c_br, c_jmp, c_comp, c_src, c_s1, c_s2, c_alu, c_mem};
    assign got_r = {r_wr, r_mwr, r_mrd, r_br, r_jmp, r_comp, r_src, r_s1, r_s2, r_alu, r_mem};

    control_unit #(.REGISTERED_OUT(1'b0)) dut_c (
        .clk               (clk),
        .rst_n             (rst_n),
        .opcode_in         (opcode),
        .reg_do_write_ctrl (c_wr),
        .mem_do_write_ctrl (c_mwr),
        .mem_do_read_ctrl  (c_mrd),
        .do_branch         (c_br),
        .do_jump           (c_jmp),
        .comp_ctrl         (c_comp),
        .reg_wr_src_ctrl   (c_src),
        .alu_src1_ctrl     (c_s1),
        .alu_src2_ctrl     (c_s2),
        .alu_ctrl          (c_alu),
        .mem_ctrl          (c_mem),
        .illegal_op        (c_ill)
    );

    control_unit #(.REGISTERED_OUT(1'b1)) dut_r (
        .clk               (clk),
        .rst_n             (rst_n),
        .opcode_in         (opcode),
        .reg_do_write_ctrl (r_wr),
        .mem_do_write_ctrl (r_mwr),
        .mem_do_read_ctrl  (r_mrd),
        .do_branch         (r_br),
        .do_jump           (r_jmp),
        .comp_ctrl         (r_comp),
        .reg_wr_src_ctrl   (r_src),
        .alu_src1_ctrl     (r_s1),
        .alu_src2_ctrl     (r_s2),
        .alu_ctrl          (r_alu),
        .mem_ctrl          (r_mem),
        .illegal_op        (r_ill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic wr, input logic mwr, input logic mrd,
                                input logic br, input logic jmp, input comp_op_t comp,
                                input reg_wr_src_t src, input alu_src1_t s1,
                                input alu_src2_t s2, input alu_op_t alu, input mem_op_t mem);
        return '{wr: wr, mwr: mwr, mrd: mrd, br: br, jmp: jmp, comp: comp, src: src,
                 s1: s1, s2: s2, alu: alu, mem: mem};
    endfunction

    localparam exp_t DEF = '{wr: 1'b0, mwr: 1'b0, mrd: 1'b0, br: 1'b0, jmp: 1'b0,
                             comp: BR_NOP, src: WRSRC_ALURES, s1: SRC1_REG1, s2: SRC2_REG2,
                             alu: ALU_NOP, mem: MEM_NOP};

    task automatic test_reset();
        exp_t want;
        want = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_REG2,
                  ALU_ADD, MEM_NOP);
        @(negedge clk);
        rst_n  = 1'b0;
        opcode = OP_ADD;
        @(posedge clk);
        #1;
        checks++;
        if (got_r !== DEF) $display("FAIL reset_reg_default: got %h want %h", got_r, DEF);
        else passed++;
        checks++;
        if (got_c !== want) $display("FAIL reset_comb_ungated: got %h want %h", got_c, want);
        else passed++;
        checks++;
        if (c_ill !== 1'b0 || r_ill !== 1'b0)
            $display("FAIL reset_illegal_clear: got %b%b want 00", c_ill, r_ill);
        else passed++;
        @(negedge clk);
        opcode = opcode_out_t'(6'h3F);
        @(posedge clk);
        #1;
        checks++;
        if (c_ill !== 1'b0) $display("FAIL reset_wins_over_set: got %b want 0", c_ill);
        else passed++;
        @(negedge clk);
        opcode = OP_NOP;
        rst_n  = 1'b1;
    endtask

    task automatic test_alu_ops();
        opcode_out_t rops[10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
                                  OP_SRA, OP_SLT, OP_SLTU};
        opcode_out_t iops[10] = '{OP_ADDI, OP_SUB, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
                                  OP_SRAI, OP_SLTI, OP_SLTIU};
        alu_op_t     alus[10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                                  ALU_SRA, ALU_SLT, ALU_SLTU};
        exp_t want;
        for (int i = 0; i < 10; i++) begin
            opcode = rops[i];
            #1;
            want = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                      SRC2_REG2, alus[i], MEM_NOP);
            checks++;
            if (got_c !== want)
                $display("FAIL rtype_%s: got %h want %h", rops[i].name(), got_c, want);
            else passed++;
        end
        // Index 1 has no immediate form (no SUBI).
        for (int i = 0; i < 10; i++) begin
            if (i != 1) begin
                opcode = iops[i];
                #1;
                want = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                          SRC2_IMM, alus[i], MEM_NOP);
                checks++;
                if (got_c !== want)
                    $display("FAIL ialu_%s: got %h want %h", iops[i].name(), got_c, want);
                else passed++;
            end
        end
    endtask

    task automatic test_mem_ops();
        opcode_out_t ops[8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        mem_op_t     mems[8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH,
                                 MEM_SW};
        exp_t want;
        for (int i = 0; i < 8; i++) begin
            opcode = ops[i];
            #1;
            if (i < 5)
                want = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1,
                          SRC2_IMM, ALU_ADD, mems[i]);
            else
                want = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                          SRC2_IMM, ALU_ADD, mems[i]);
            checks++;
            if (got_c !== want)
                $display("FAIL mem_%s: got %h want %h", ops[i].name(), got_c, want);
            else passed++;
        end
    endtask

    task automatic test_branch();
        opcode_out_t ops[6]  = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
        comp_op_t    cmps[6] = '{BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
        exp_t want;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            #1;
            want = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cmps[i], WRSRC_ALURES, SRC1_PC, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
            checks++;
            if (got_c !== want)
                $display("FAIL branch_%s: got %h want %h", ops[i].name(), got_c, want);
            else passed++;
        end
    endtask

    task automatic test_jump_upper();
        opcode_out_t ops[5] = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_NOP};
        exp_t        wants[5];
        wants[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BR_NOP, WRSRC_PC4, SRC1_PC, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
        wants[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BR_NOP, WRSRC_PC4, SRC1_REG1, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
        wants[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                      SRC2_IMM, ALU_LUI, MEM_NOP);
        wants[3] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_PC, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
        wants[4] = DEF;
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (got_c !== wants[i])
                $display("FAIL op_%s: got %h want %h", ops[i].name(), got_c, wants[i]);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        opcode = OP_ECALL;
        #1;
        checks++;
        if (got_c !== DEF) $display("FAIL illegal_default_bundle: got %h want %h", got_c, DEF);
        else passed++;
        checks++;
        if (c_ill !== 1'b0) $display("FAIL illegal_not_before_edge: got %b want 0", c_ill);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (c_ill !== 1'b1 || r_ill !== 1'b1)
            $display("FAIL illegal_set: got %b%b want 11", c_ill, r_ill);
        else passed++;
        @(negedge clk);
        opcode = OP_NOP;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (c_ill !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", c_ill);
        else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (c_ill !== 1'b0) $display("FAIL illegal_reset_clear: got %b want 0", c_ill);
        else passed++;
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = opcode_out_t'(6'h3F);
        #1;
        checks++;
        if (got_c !== DEF) $display("FAIL illegal_raw_default: got %h want %h", got_c, DEF);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (c_ill !== 1'b1) $display("FAIL illegal_raw_set: got %b want 1", c_ill);
        else passed++;
        @(negedge clk);
        opcode = OP_NOP;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic test_registered();
        exp_t want;
        want = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,
                  ALU_ADD, MEM_LW);
        @(negedge clk);
        opcode = OP_LW;
        #1;
        checks++;
        if (got_r !== DEF) $display("FAIL reg_latency: got %h want %h", got_r, DEF);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (got_r !== want) $display("FAIL reg_lw: got %h want %h", got_r, want);
        else passed++;
    endtask

    task automatic test_back_to_back();
        opcode_out_t ops[5] = '{OP_ADD, OP_SW, OP_BEQ, OP_JALR, OP_LUI};
        exp_t        wants[5];
        exp_t        jal;
        wants[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                      SRC2_REG2, ALU_ADD, MEM_NOP);
        wants[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                      SRC2_IMM, ALU_ADD, MEM_SW);
        wants[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, BR_EQ, WRSRC_ALURES, SRC1_PC, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
        wants[3] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BR_NOP, WRSRC_PC4, SRC1_REG1, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
        wants[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR_NOP, WRSRC_ALURES, SRC1_REG1,
                      SRC2_IMM, ALU_LUI, MEM_NOP);
        jal      = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BR_NOP, WRSRC_PC4, SRC1_PC, SRC2_IMM,
                      ALU_ADD, MEM_NOP);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opcode = ops[i];
            @(posedge clk);
            #1;
            checks++;
            if (got_r !== wants[i])
                $display("FAIL b2b_%s: got %h want %h", ops[i].name(), got_r, wants[i]);
            else passed++;
        end
        @(negedge clk);
        opcode = OP_JAL;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got_r !== DEF) $display("FAIL b2b_reset_drop: got %h want %h", got_r, DEF);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (got_r !== jal) $display("FAIL b2b_after_reset: got %h want %h", got_r, jal);
        else passed++;
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = OP_NOP;
        test_reset();
        test_alu_ops();
        test_mem_ops();
        test_branch();
        test_jump_upper();
        test_illegal();
        test_registered();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
